// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// bit-serial addition controller (slave).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: feeds one shared 1-bit full adder LSB first, one bit per
// clock, and publishes {cout, sum} together with a single-cycle done pulse.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] sum_sh_reg, sum_sh_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shifted;

    full_adder u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_single
            assign sum_shifted = fa_s;
        end else begin : g_multi
            assign sum_shifted = {fa_s, sum_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        sum_sh_next = sum_sh_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cout_next   = cout_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = RUN;
                    a_sh_next   = bus.a;
                    b_sh_next   = bus.b;
                    carry_next  = bus.cin;
                    cnt_next    = '0;
                    sum_sh_next = '0;
                    sum_next    = '0;
                    cout_next   = 1'b0;
                end
            end
            RUN: begin
                sum_sh_next = sum_shifted;
                carry_next  = fa_c;
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    sum_next   = sum_shifted;
                    cout_next  = fa_c;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            sum_sh_reg <= sum_sh_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cout_reg   <= cout_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, with a
// result scoreboard per instance popped on each done pulse.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic done8_prev = 1'b0;
    logic done1_prev = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;
    vec_t vecs[8];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Result monitors: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst) begin
            done8_prev <= 1'b0;
            done1_prev <= 1'b0;
        end else begin
            if (bus8.done) begin
                check("w8_busy_done_excl", bus8.busy, 0);
                check("w8_done_pulse", done8_prev, 0);
                if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
                else check("w8_result", {bus8.cout, bus8.sum}, q8.pop_front());
            end
            if (bus1.done) begin
                check("w1_busy_done_excl", bus1.busy, 0);
                check("w1_done_pulse", done1_prev, 0);
                if (q1.size() == 0) check("w1_unexpected_done", 1, 0);
                else check("w1_result", {bus1.cout, bus1.sum}, q1.pop_front());
            end
            done8_prev <= bus8.done;
            done1_prev <= bus1.done;
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [8:0] exp);
        int cyc;
        int busy_n;
        bit seen;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        bus8.start = 1'b0;
        check("w8_cleared_in_run", {bus8.cout, bus8.sum}, 0);
        busy_n = 0;
        seen = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (bus8.done) begin seen = 1; break; end
            if (bus8.busy) busy_n++;
            @(negedge clk);
        end
        check("w8_timeout", seen, 1);
        check("w8_latency", cyc, 8);
        check("w8_busy_cycles", busy_n, 8);
        $display("w8 op a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h", a, b, cin, bus8.cout, bus8.sum);
    endtask

    task automatic op1(input logic a, input logic b, input logic cin, input logic [1:0] exp);
        int cyc;
        int busy_n;
        bit seen;
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
        q1.push_back(exp);
        @(negedge clk);
        bus1.start = 1'b0;
        busy_n = 0;
        seen = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (bus1.done) begin seen = 1; break; end
            if (bus1.busy) busy_n++;
            @(negedge clk);
        end
        check("w1_timeout", seen, 1);
        check("w1_latency", cyc, 1);
        check("w1_busy_cycles", busy_n, 1);
        $display("w1 op a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", a, b, cin, bus1.cout, bus1.sum);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        bit         seen;

        vecs[0] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset held two cycles with start asserted: nothing may start.
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b1;  bus1.cin = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_w8_busy", bus8.busy, 0);
        check("rst_w8_done", bus8.done, 0);
        check("rst_w8_sum", bus8.sum, 0);
        check("rst_w8_cout", bus8.cout, 0);
        check("rst_w1_busy", bus1.busy, 0);
        check("rst_w1_done", bus1.done, 0);
        check("rst_w1_sum", bus1.sum, 0);
        check("rst_w1_cout", bus1.cout, 0);
        rst = 1'b0;
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        check("post_rst_w8_idle", bus8.busy, 0);

        foreach (vecs[i]) op8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});

        // Start held high with operands toggling during RUN; the second
        // request must be accepted exactly WIDTH+2 cycles after the first.
        @(negedge clk);
        bus8.a = 8'h3C; bus8.b = 8'hC5; bus8.cin = 1'b1; bus8.start = 1'b1;
        q8.push_back(9'h102);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus8.done) begin seen = 1; break; end
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        end
        check("dist1_timeout", seen, 1);
        bus8.a = 8'h81; bus8.b = 8'h7F; bus8.cin = 1'b0;
        q8.push_back(9'h100);
        @(negedge clk);
        check("dist_gap_idle", bus8.busy, 0);
        @(negedge clk);
        check("dist_reaccept", bus8.busy, 1);
        bus8.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            @(negedge clk);
            if (bus8.done) begin seen = 1; break; end
        end
        check("dist2_timeout", seen, 1);
        $display("w8 disturbance ops done, last cout=%0d sum=%02h", bus8.cout, bus8.sum);

        // Reset during the 4th RUN cycle abandons the operation.
        @(negedge clk);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_busy", bus8.busy, 0);
        check("abort_sum", bus8.sum, 0);
        check("abort_cout", bus8.cout, 0);
        $display("w8 abort: busy=%0d sum=%02h cout=%0d", bus8.busy, bus8.sum, bus8.cout);
        op8(8'h12, 8'h34, 1'b0, 9'h046);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        for (int i = 0; i < 8; i++) op1(1'(i >> 2), 1'(i >> 1), 1'(i), 2'(((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)));
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rc = 1'($urandom);
            op1(ra[0], rb[0], rc, 2'(ra[0]) + 2'(rb[0]) + 2'(rc));
        end

        repeat (3) @(negedge clk);
        check("w8_scoreboard_drained", q8.size(), 0);
        check("w1_scoreboard_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences one instance of the team's 1-bit `full_adder` over WIDTH-bit operands, LSB first, one bit per clock. It captures operands on a start request and feeds the adder one bit pair per cycle, carrying through a carry flip-flop. It assembles the sum in a shift register and signals completion with a one-cycle done pulse. It sits between a requesting datapath and the shared 1-bit adder, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while state = RUN.
- done  output  1  one-cycle pulse, high while state = DONE.
- sum  output  WIDTH  result; registered, holds until next accepted start.
- cout  output  1  final carry-out; registered, holds like sum.

## Operation
- Internal regs: a_sh, b_sh (WIDTH), sum_sh (WIDTH), carry (1), bit counter cnt (clog2(WIDTH+1) bits), 2-bit state.
- One `full_adder` instance: inputs a_sh[0], b_sh[0], carry; outputs s, c.
- FSM states: IDLE, RUN, DONE.
  - IDLE with start=1 -> RUN. Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0. Clear sum and cout to 0.
  - IDLE with start=0 -> stay in IDLE.
  - RUN, every cycle:
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
    - carry <= c.
    - a_sh and b_sh shift right by 1, zero-filled.
    - cnt <= cnt+1.
  - RUN with cnt == WIDTH-1 -> DONE. On that same edge, sum <= {s, sum_sh[WIDTH-1:1]} and cout <= c.
  - DONE -> IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued, and the requester must re-assert it once back in IDLE.
- Changes on a, b and cin after acceptance have no effect on the operation in progress.
- Result: {cout, sum} == a + b + cin, computed modulo 2^(WIDTH+1), i.e. exact.
- WIDTH=1: RUN lasts exactly one cycle; behaviour is otherwise identical.
- Reset:
  - State goes to IDLE. busy=0, done=0, sum=0, cout=0, and all internal registers are 0.
  - Reset asserted mid-RUN or in DONE abandons the operation. No done pulse is produced and sum/cout read 0.
  - Reset has priority over start in the same cycle.

## Timing
- Start sampled at edge k in IDLE:
  - busy=1 during cycles k+1 .. k+WIDTH.
  - done=1 in cycle k+WIDTH+1, with busy=0.
- sum and cout are valid from cycle k+WIDTH+1, in the same cycle done is high, and they hold thereafter.
- sum and cout are cleared to 0 during cycles k+1 .. k+WIDTH.
- Latency is WIDTH+1 cycles from start to done. The earliest next accepted start is at edge k+WIDTH+2, which gives WIDTH+2 cycles per operation.
- busy and done are never high simultaneously. done is never high for 2 consecutive cycles.
- The full_adder path is combinational between registers. The critical path is carry reg -> full_adder -> carry reg and sum_sh.

## Test plan
- Reset check: assert rst for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0. No operation starts while rst=1.
- Basic add, WIDTH=8, a=0x5A, b=0x3C, cin=1, start pulsed 1 cycle -> busy high for exactly 8 cycles, then done pulse in cycle 9 with sum=0x97, cout=0.
- Carry ripple:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Busy-time disturbance: start held high continuously, with a/b/cin toggled every cycle during RUN -> result matches the operands captured at acceptance. The next operation is accepted exactly WIDTH+2 cycles after the first.
- Reset mid-operation: a=0x12, b=0x34, rst pulsed at the 4th RUN cycle -> no done pulse, sum=0x00, cout=0. A subsequent start with a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Random and WIDTH corners: 1000 random vectors each at WIDTH=8 and WIDTH=1 -> {cout,sum} == a+b+cin every time. done is a single-cycle pulse at WIDTH+1 cycles after start.
